// File: rtl/fifo_byte_serializer_pkg.sv
// Shared FSM state types and FIFO condition codes for the byte serializer.
// No logic; imported by the fetch controller, the top and the bench.
// Condition code 2'b01 is unused by the FIFO and is treated as non-empty.
package fifo_ser_pkg;

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_GUARD} fetch_state_t;
    typedef enum logic {S_IDLE, S_SHIFT} shift_state_t;

    localparam logic [1:0] FIFO_EMPTY = 2'b00;
    localparam logic [1:0] FIFO_PART  = 2'b10;
    localparam logic [1:0] FIFO_FULL  = 2'b11;

    function automatic logic fifo_has_data(input logic [1:0] cond);
        case (cond)
            FIFO_PART, FIFO_FULL: return 1'b1;
            FIFO_EMPTY:           return 1'b0;
            default:              return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/fifo_byte_serializer_if.sv
// FIFO read port plus serial bit stream of the byte serializer.
// master = serializer side, slave = FIFO/downstream side.
// bit_ready is the only backpressure; the FIFO side has none.
interface fifo_byte_serializer_if #(
    parameter int BYTE_W = 8
);
    logic [1:0]        fifo_cond;
    logic [BYTE_W-1:0] fifo_dout;
    logic              fifo_stb;
    logic              fifo_read;
    logic              bit_ready;
    logic              bit_out;
    logic              bit_valid;
    logic              bit_last;

    modport master (
        input  fifo_cond, fifo_dout, fifo_stb, bit_ready,
        output fifo_read, bit_out, bit_valid, bit_last
    );

    modport slave (
        output fifo_cond, fifo_dout, fifo_stb, bit_ready,
        input  fifo_read, bit_out, bit_valid, bit_last
    );
endinterface

// File: rtl/fifo_byte_serializer_read_ctrl.sv
// Fetch FSM: pulls one byte from the FIFO into a one-entry prefetch buffer.
// Latency: read issued 1 cycle after non-empty seen, byte buffered 2 cycles later.
// Backpressure: no new read while the buffer is full; buffer freed by buf_take.
module fifo_read_ctrl
    import fifo_ser_pkg::*;
#(
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        fifo_cond,
    input  logic [BYTE_W-1:0] fifo_dout,
    input  logic              fifo_stb,
    output logic              fifo_read,
    input  logic              buf_take,
    output logic              buf_full,
    output logic [BYTE_W-1:0] buf_dat,
    output logic              fetch_busy,
    output logic              stb_err
);

    fetch_state_t state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= F_IDLE;
            fifo_read <= 1'b0;
            buf_full  <= 1'b0;
            buf_dat   <= '0;
            stb_err   <= 1'b0;
        end else begin
            fifo_read <= 1'b0;
            if (buf_take)
                buf_full <= 1'b0;
            if (fifo_stb && state != F_WAIT)
                stb_err <= 1'b1;
            case (state)
                F_IDLE: begin
                    if (fifo_has_data(fifo_cond) && !buf_full) begin
                        state     <= F_REQ;
                        fifo_read <= 1'b1;
                    end
                end
                F_REQ: state <= F_WAIT;
                F_WAIT: begin
                    // A capture overrides a same-edge take so the new byte is kept.
                    if (fifo_stb) begin
                        buf_dat  <= fifo_dout;
                        buf_full <= 1'b1;
                        state    <= F_GUARD;
                    end else begin
                        stb_err <= 1'b1;
                        state   <= F_IDLE;
                    end
                end
                F_GUARD: state <= F_IDLE;
                default: state <= F_IDLE;
            endcase
        end
    end

    assign fetch_busy = (state == F_REQ) || (state == F_WAIT);

endmodule

// File: rtl/fifo_byte_serializer.sv
// Drains bytes from the byte FIFO and serialises them into a valid/ready bit stream.
// Latency: first bit valid 4 cycles after non-empty seen; then 1 bit/cycle, no bubbles.
// Backpressure: bit_ready low holds bit_out/bit_last; FIFO_SER_PARITY_EN appends even parity.
module fifo_byte_serializer
    import fifo_ser_pkg::*;
#(
    parameter int BYTE_W    = 8,
    parameter int LSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_byte_serializer_if.master bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      bytes_sent,
    output logic                  stb_err
);

`ifdef FIFO_SER_PARITY_EN
    localparam int FRAME_W = BYTE_W + 1;
`else
    localparam int FRAME_W = BYTE_W;
`endif
    localparam int                BIT_CW   = $clog2(FRAME_W);
    localparam logic [BIT_CW-1:0] LAST_IDX = BIT_CW'(FRAME_W - 1);

    logic              buf_full;
    logic [BYTE_W-1:0] buf_dat;
    logic              buf_take;
    logic              fetch_busy;

    shift_state_t       sstate;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] load_frame;
    logic [FRAME_W-1:0] shifted;
    logic [BIT_CW-1:0]  bit_cnt;
    logic [BIT_CW-1:0]  next_cnt;
    logic               bit_valid;
    logic               bit_last;
    logic               final_xfer;

    fifo_read_ctrl #(.BYTE_W(BYTE_W)) u_read_ctrl (
        .clk        (clk),
        .rst        (rst),
        .fifo_cond  (bus.fifo_cond),
        .fifo_dout  (bus.fifo_dout),
        .fifo_stb   (bus.fifo_stb),
        .fifo_read  (bus.fifo_read),
        .buf_take   (buf_take),
        .buf_full   (buf_full),
        .buf_dat    (buf_dat),
        .fetch_busy (fetch_busy),
        .stb_err    (stb_err)
    );

    // Parity sits at the far end of the frame so it always leaves last.
    always_comb begin
        load_frame = '0;
`ifdef FIFO_SER_PARITY_EN
        if (LSB_FIRST != 0)
            load_frame = {^buf_dat, buf_dat};
        else
            load_frame = {buf_dat, ^buf_dat};
`else
        load_frame = buf_dat;
`endif
    end

    assign shifted    = (LSB_FIRST != 0) ? (frame >> 1) : (frame << 1);
    assign next_cnt   = bit_cnt + 1'b1;
    assign final_xfer = bit_valid && bus.bit_ready && bit_last;
    // Reload straight from the buffer on the last bit so the stream has no gap.
    assign buf_take   = buf_full && ((sstate == S_IDLE) || final_xfer);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sstate     <= S_IDLE;
            frame      <= '0;
            bit_cnt    <= '0;
            bit_valid  <= 1'b0;
            bit_last   <= 1'b0;
            bytes_sent <= '0;
        end else begin
            if (final_xfer)
                bytes_sent <= bytes_sent + 1'b1;
            if (buf_take) begin
                sstate    <= S_SHIFT;
                frame     <= load_frame;
                bit_cnt   <= '0;
                bit_valid <= 1'b1;
                bit_last  <= 1'b0;
            end else if (sstate == S_SHIFT && bus.bit_ready) begin
                if (bit_last) begin
                    sstate    <= S_IDLE;
                    frame     <= '0;
                    bit_cnt   <= '0;
                    bit_valid <= 1'b0;
                    bit_last  <= 1'b0;
                end else begin
                    frame    <= shifted;
                    bit_cnt  <= next_cnt;
                    bit_last <= (next_cnt == LAST_IDX);
                end
            end
        end
    end

    assign bus.bit_out   = (LSB_FIRST != 0) ? frame[0] : frame[FRAME_W-1];
    assign bus.bit_valid = bit_valid;
    assign bus.bit_last  = bit_last;
    assign busy          = buf_full || (sstate == S_SHIFT) || fetch_busy;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench for fifo_byte_serializer with a behavioural byte FIFO (1-cycle read strobe).
// Builds with or without FIFO_SER_PARITY_EN; frame length follows the macro.
`timescale 1ns/1ps
module tb_fifo_byte_serializer;
    import fifo_ser_pkg::*;

`ifdef FIFO_SER_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif
    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic [15:0] bytes_sent;
    logic        stb_err;

    fifo_byte_serializer_if #(.BYTE_W(8)) bus();

    fifo_byte_serializer #(.BYTE_W(8), .LSB_FIRST(1), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .bytes_sent (bytes_sent),
        .stb_err    (stb_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte FIFO model: the bench only appends to push_q, the model only advances pop_idx.
    logic [7:0] push_q[$];
    int         pop_idx   = 0;
    int         cyc       = 0;
    logic [1:0] m_cond    = FIFO_EMPTY;
    logic [7:0] m_dout    = 8'h00;
    logic       m_stb     = 1'b0;
    logic       drop_stb  = 1'b0;
    logic       spur_stb  = 1'b0;

    assign bus.fifo_cond = m_cond;
    assign bus.fifo_dout = m_dout;
    assign bus.fifo_stb  = m_stb;

    always @(posedge clk) begin : fifo_model
        int left;
        cyc++;
        if (bus.fifo_read) begin
            if (pop_idx < push_q.size()) begin
                m_dout <= push_q[pop_idx];
                pop_idx++;
            end
            m_stb <= !drop_stb;
        end else if (spur_stb) begin
            m_dout <= 8'hEE;
            m_stb  <= 1'b1;
        end else begin
            m_stb <= 1'b0;
        end
        left = push_q.size() - pop_idx;
        m_cond <= (left == 0) ? FIFO_EMPTY : ((left >= DEPTH) ? FIFO_FULL : FIFO_PART);
    end

    // Bit-stream monitor.
    logic bitq[$];
    logic lastq[$];
    int   cycq[$];
    int   reads    = 0;
    int   hold_err = 0;
    logic prev_stall = 1'b0;
    logic prev_bit   = 1'b0;
    logic prev_last  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall && (bus.bit_out !== prev_bit || bus.bit_last !== prev_last || bus.bit_valid !== 1'b1))
                hold_err++;
            prev_stall = bus.bit_valid && !bus.bit_ready;
            prev_bit   = bus.bit_out;
            prev_last  = bus.bit_last;
            if (bus.bit_valid && bus.bit_ready) begin
                bitq.push_back(bus.bit_out);
                lastq.push_back(bus.bit_last);
                cycq.push_back(cyc);
            end
            if (bus.fifo_read)
                reads++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    int rd_ptr = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_bits(input string tag, input int n, input int budget);
        int k = 0;
        while (bitq.size() < rd_ptr + n && k < budget) begin
            tick(1);
            k++;
        end
        if (bitq.size() < rd_ptr + n)
            chk({tag, "_timeout"}, bitq.size() - rd_ptr, n);
    endtask

    // par is the hand-computed even-parity bit, used only when frames carry parity.
    task automatic check_frame(input string tag, input logic [7:0] b, input logic par);
        for (int i = 0; i < FRAME; i++) begin
            logic eb, el, gb, gl;
            eb = (i < 8) ? b[i] : par;
            el = (i == FRAME - 1);
            gb = 1'bx;
            gl = 1'bx;
            if (rd_ptr < bitq.size()) begin
                gb = bitq[rd_ptr];
                gl = lastq[rd_ptr];
            end
            rd_ptr++;
            chk($sformatf("%s_bit%0d", tag, i), gb, eb);
            chk($sformatf("%s_last%0d", tag, i), gl, el);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        rd_ptr = bitq.size();
        tick(1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int push_cyc, start, gaps, rd0, hold0;
        bus.bit_ready = 1'b0;

        // Reset state
        tick(3);
        chk("rst_bit_valid", bus.bit_valid, 0);
        chk("rst_bit_out", bus.bit_out, 0);
        chk("rst_bit_last", bus.bit_last, 0);
        chk("rst_fifo_read", bus.fifo_read, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bytes_sent", bytes_sent, 0);
        chk("rst_stb_err", stb_err, 0);
        rst = 1'b1;
        tick(2);

        // 1: single byte A5, latency and single read
        bus.bit_ready = 1'b1;
        rd0 = reads;
        push_cyc = cyc;
        push_q.push_back(8'hA5);
        start = rd_ptr;
        wait_bits("t1", FRAME, 40);
        chk("t1_latency", (start < cycq.size()) ? cycq[start] - push_cyc : -1, 5);
        check_frame("t1", 8'hA5, 1'b0);
        tick(20);
        chk("t1_reads", reads - rd0, 1);
        chk("t1_bytes_sent", bytes_sent, 1);
        chk("t1_idle_valid", bus.bit_valid, 0);
        chk("t1_idle_busy", busy, 0);

        // 2: three bytes back to back, FIFO starts full
        rd0 = reads;
        push_q.push_back(8'h01);
        push_q.push_back(8'h80);
        push_q.push_back(8'hFF);
        start = rd_ptr;
        wait_bits("t2", 3 * FRAME, 120);
        gaps = 0;
        for (int j = start + 1; j < start + 3 * FRAME && j < cycq.size(); j++)
            if (cycq[j] != cycq[j-1] + 1)
                gaps++;
        chk("t2_bubbles", gaps, 0);
        check_frame("t2a", 8'h01, 1'b1);
        check_frame("t2b", 8'h80, 1'b1);
        check_frame("t2c", 8'hFF, 1'b0);
        tick(10);
        chk("t2_reads", reads - rd0, 3);
        chk("t2_bytes_sent", bytes_sent, 4);

        // 3: bit_ready toggling on 3C
        rd0 = reads;
        hold0 = hold_err;
        push_q.push_back(8'h3C);
        for (int k = 0; k < 200 && bitq.size() < rd_ptr + FRAME; k++) begin
            bus.bit_ready = ~bus.bit_ready;
            tick(1);
        end
        bus.bit_ready = 1'b1;
        wait_bits("t3", FRAME, 10);
        check_frame("t3", 8'h3C, 1'b0);
        tick(10);
        chk("t3_hold", hold_err - hold0, 0);
        chk("t3_reads", reads - rd0, 1);
        chk("t3_bytes_sent", bytes_sent, 5);

        // 4: reset mid-frame of F0, then clean restart
        push_q.push_back(8'hF0);
        wait_bits("t4", 3, 40);
        rst = 1'b0;
        @(negedge clk);
        chk("t4_bit_valid", bus.bit_valid, 0);
        chk("t4_bit_out", bus.bit_out, 0);
        chk("t4_bit_last", bus.bit_last, 0);
        chk("t4_fifo_read", bus.fifo_read, 0);
        chk("t4_busy", busy, 0);
        chk("t4_bytes_sent", bytes_sent, 0);
        tick(2);
        rst = 1'b1;
        rd_ptr = bitq.size();
        tick(2);
        push_q.push_back(8'h96);
        wait_bits("t4r", FRAME, 40);
        check_frame("t4r", 8'h96, 1'b0);
        tick(5);
        chk("t4r_bytes_sent", bytes_sent, 1);

        // 5a: spurious strobe while idle
        pulse_reset();
        chk("t5_err_clear", stb_err, 0);
        spur_stb = 1'b1;
        tick(1);
        spur_stb = 1'b0;
        tick(3);
        chk("t5_spur_err", stb_err, 1);
        tick(5);
        chk("t5_spur_sticky", stb_err, 1);
        chk("t5_spur_nodata", bitq.size() - rd_ptr, 0);
        chk("t5_spur_busy", busy, 0);

        // 5b: missing strobe in F_WAIT
        pulse_reset();
        rd0 = reads;
        drop_stb = 1'b1;
        push_q.push_back(8'h77);
        tick(15);
        drop_stb = 1'b0;
        chk("t5_drop_reads", reads - rd0, 1);
        chk("t5_drop_err", stb_err, 1);
        chk("t5_drop_nodata", bitq.size() - rd_ptr, 0);
        chk("t5_drop_valid", bus.bit_valid, 0);
        chk("t5_drop_busy", busy, 0);
        chk("t5_drop_bytes", bytes_sent, 0);

`ifdef FIFO_SER_PARITY_EN
        // 6: parity bit on 07 (odd weight) and 03 (even weight)
        pulse_reset();
        push_q.push_back(8'h07);
        wait_bits("t6a", FRAME, 40);
        check_frame("t6a", 8'h07, 1'b1);
        push_q.push_back(8'h03);
        wait_bits("t6b", FRAME, 40);
        check_frame("t6b", 8'h03, 1'b0);
        tick(5);
        chk("t6_bytes_sent", bytes_sent, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
